// File: rtl/fracn_hop_ctrl.sv
// Frequency-hop controller for a fractional-N divider: holds a 4-entry profile
// table and sequences APPLY -> CLEAR -> SETTLE on each accepted hop request.
module fracn_hop_ctrl #(
    parameter int INT_WIDTH    = 8,
    parameter int FRAC_WIDTH   = 24,
    parameter int SETTLE_WIDTH = 16,
    parameter int INT_RESET    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [INT_WIDTH-1:0]    cfg_int,
    input  logic [FRAC_WIDTH-1:0]   cfg_frac,
    input  logic [SETTLE_WIDTH-1:0] settle_cycles,
    input  logic                    hop_valid,
    input  logic [1:0]              hop_idx,
    output logic                    hop_ready,
    output logic [INT_WIDTH-1:0]    Integer,
    output logic [FRAC_WIDTH-1:0]   Fraction,
    output logic                    mod_clr,
    output logic                    busy,
    output logic                    settled,
    output logic                    hop_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        CLEAR  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q;
    logic [SETTLE_WIDTH-1:0] cnt_q;
    logic [INT_WIDTH-1:0]    int_q;
    logic [FRAC_WIDTH-1:0]   frac_q;
    logic                    mod_clr_q, mod_clr_d;
    logic                    hop_done_q, hop_done_d;
    logic                    busy_q, busy_d;
    logic                    settled_q, settled_d;
    logic                    accept;
    logic                    cnt_zero;

    logic [INT_WIDTH-1:0]    tbl_int_q  [4];
    logic [FRAC_WIDTH-1:0]   tbl_frac_q [4];

    assign accept   = hop_valid && (state_q == IDLE);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hop_valid) state_d = APPLY;
            APPLY:   state_d = CLEAR;
            CLEAR:   state_d = SETTLE;
            SETTLE:  if (cnt_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are computed one cycle early so they leave flops directly.
    always_comb begin
        mod_clr_d  = (state_q == APPLY);
        hop_done_d = (state_q == SETTLE) && cnt_zero;
        busy_d     = (state_d != IDLE);
        settled_d  = settled_q;
        if (accept) begin
            settled_d = 1'b0;
        end else if (hop_done_d) begin
            settled_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_clr_q  <= 1'b0;
            hop_done_q <= 1'b0;
            busy_q     <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            mod_clr_q  <= mod_clr_d;
            hop_done_q <= hop_done_d;
            busy_q     <= busy_d;
            settled_q  <= settled_d;
        end
    end

    // Table reads in APPLY see the pre-edge contents, so a same-cycle write
    // to the selected entry only affects later hops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            int_q  <= INT_WIDTH'(INT_RESET);
            frac_q <= '0;
            for (int i = 0; i < 4; i++) begin
                tbl_int_q[i]  <= '0;
                tbl_frac_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                idx_q <= hop_idx;
            end
            if (state_q == APPLY) begin
                int_q  <= tbl_int_q[idx_q];
                frac_q <= tbl_frac_q[idx_q];
            end
            if (state_q == CLEAR) begin
                cnt_q <= settle_cycles;
            end else if ((state_q == SETTLE) && !cnt_zero) begin
                cnt_q <= cnt_q - SETTLE_WIDTH'(1);
            end
            if (cfg_we) begin
                tbl_int_q[cfg_addr]  <= cfg_int;
                tbl_frac_q[cfg_addr] <= cfg_frac;
            end
        end
    end

    assign hop_ready = (state_q == IDLE);
    assign Integer   = int_q;
    assign Fraction  = frac_q;
    assign mod_clr   = mod_clr_q;
    assign busy      = busy_q;
    assign settled   = settled_q;
    assign hop_done  = hop_done_q;

endmodule

// File: tb/tb_fracn_hop_ctrl.sv
// Directed bench for fracn_hop_ctrl: a table of single hops plus hand-written
// sequences for back-to-back hops, APPLY-cycle writes, reset aborts and settle changes.
module tb_fracn_hop_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [7:0]  cfg_int = '0;
    logic [23:0] cfg_frac = '0;
    logic [15:0] settle_cycles = '0;
    logic        hop_valid = 1'b0;
    logic [1:0]  hop_idx = '0;
    logic        hop_ready;
    logic [7:0]  Integer;
    logic [23:0] Fraction;
    logic        mod_clr;
    logic        busy;
    logic        settled;
    logic        hop_done;

    int passed = 0;
    int total  = 0;

    fracn_hop_ctrl #(
        .INT_WIDTH(8), .FRAC_WIDTH(24), .SETTLE_WIDTH(16), .INT_RESET(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_int(cfg_int), .cfg_frac(cfg_frac), .settle_cycles(settle_cycles),
        .hop_valid(hop_valid), .hop_idx(hop_idx), .hop_ready(hop_ready),
        .Integer(Integer), .Fraction(Fraction), .mod_clr(mod_clr), .busy(busy),
        .settled(settled), .hop_done(hop_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  idx;
        logic [7:0]  wr_int;
        logic [23:0] wr_frac;
        logic [15:0] s;
        logic [7:0]  exp_int;
        logic [23:0] exp_frac;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [7:0] i, input logic [23:0] f);
        cfg_we = 1'b1; cfg_addr = a; cfg_int = i; cfg_frac = f;
        tick();
        cfg_we = 1'b0;
    endtask

    // Issues a hop in the current cycle N and checks every cycle through N+5+S.
    task automatic do_hop(input string nm, input logic [1:0] idx, input logic [15:0] s,
                          input logic [7:0] ei, input logic [23:0] ef);
        int last;
        last = 4 + int'(s);
        chk({nm, "_ready_N"}, 32'(hop_ready), 32'd1);
        hop_valid = 1'b1; hop_idx = idx; settle_cycles = s;
        tick();
        hop_valid = 1'b0;
        chk({nm, "_busy_N1"}, 32'(busy), 32'd1);
        chk({nm, "_ready_N1"}, 32'(hop_ready), 32'd0);
        chk({nm, "_settled_N1"}, 32'(settled), 32'd0);
        chk({nm, "_modclr_N1"}, 32'(mod_clr), 32'd0);
        tick();
        chk({nm, "_int_N2"}, 32'(Integer), 32'(ei));
        chk({nm, "_frac_N2"}, 32'(Fraction), 32'(ef));
        chk({nm, "_modclr_N2"}, 32'(mod_clr), 32'd1);
        for (int k = 3; k <= last; k++) begin
            tick();
            chk($sformatf("%s_done_N%0d", nm, k), 32'(hop_done), 32'(k == last));
            chk($sformatf("%s_modclr_N%0d", nm, k), 32'(mod_clr), 32'd0);
        end
        chk({nm, "_settled_end"}, 32'(settled), 32'd1);
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
        chk({nm, "_ready_end"}, 32'(hop_ready), 32'd1);
        tick();
        chk({nm, "_done_after"}, 32'(hop_done), 32'd0);
        chk({nm, "_settled_hold"}, 32'(settled), 32'd1);
    endtask

    initial begin
        int n_clr;
        int n_done;

        vecs[0] = '{"v0_idx1_s3",   1'b1, 2'd1, 8'd20,  24'h400000, 16'd3, 8'd20,  24'h400000};
        vecs[1] = '{"v1_idx0_s0",   1'b0, 2'd0, 8'd0,   24'h000000, 16'd0, 8'd0,   24'h000000};
        vecs[2] = '{"v2_idx2_max",  1'b1, 2'd2, 8'hFF,  24'hFFFFFF, 16'd1, 8'hFF,  24'hFFFFFF};
        vecs[3] = '{"v3_idx3_s2",   1'b1, 2'd3, 8'h01,  24'h000001, 16'd2, 8'h01,  24'h000001};

        // Reset values before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_int", 32'(Integer), 32'd16);
        chk("rst_frac", 32'(Fraction), 32'd0);
        chk("rst_modclr", 32'(mod_clr), 32'd0);
        chk("rst_done", 32'(hop_done), 32'd0);
        chk("rst_settled", 32'(settled), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(hop_ready), 32'd1);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_int", 32'(Integer), 32'd16);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].we) write_entry(vecs[v].idx, vecs[v].wr_int, vecs[v].wr_frac);
            do_hop(vecs[v].name, vecs[v].idx, vecs[v].s, vecs[v].exp_int, vecs[v].exp_frac);
        end

        // Back-to-back: valid held high, idx switches to 2 once the first hop is taken
        write_entry(2'd2, 8'd30, 24'h123456);
        n_clr = 0;
        n_done = 0;
        hop_valid = 1'b1; hop_idx = 2'd0; settle_cycles = 16'd1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) hop_idx = 2'd2;
            if (k == 6) hop_valid = 1'b0;
            if (mod_clr) n_clr++;
            if (hop_done) n_done++;
            if (k <= 4 || (k >= 6 && k <= 9))
                chk($sformatf("b2b_ready_k%0d", k), 32'(hop_ready), 32'd0);
            if (k == 5 || k == 10) begin
                chk($sformatf("b2b_done_k%0d", k), 32'(hop_done), 32'd1);
                chk($sformatf("b2b_ready_k%0d", k), 32'(hop_ready), 32'd1);
            end
            if (k == 2) chk("b2b_int_first", 32'(Integer), 32'd0);
            if (k == 7) begin
                chk("b2b_int_second", 32'(Integer), 32'd30);
                chk("b2b_frac_second", 32'(Fraction), 32'h123456);
            end
        end
        chk("b2b_modclr_count", 32'(n_clr), 32'd2);
        chk("b2b_done_count", 32'(n_done), 32'd2);

        // Write to entry 1 during its own APPLY cycle
        hop_valid = 1'b1; hop_idx = 2'd1; settle_cycles = 16'd0;
        tick();
        hop_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_int = 8'd40; cfg_frac = 24'hABCDEF;
        tick();
        cfg_we = 1'b0;
        chk("apw_old_int", 32'(Integer), 32'd20);
        chk("apw_old_frac", 32'(Fraction), 32'h400000);
        tick();
        tick();
        chk("apw_done", 32'(hop_done), 32'd1);
        tick();
        do_hop("apw_new", 2'd1, 16'd0, 8'd40, 24'hABCDEF);

        // Reset asserted mid-SETTLE aborts the hop
        hop_valid = 1'b1; hop_idx = 2'd3; settle_cycles = 16'd5;
        tick();
        hop_valid = 1'b0;
        tick();
        tick();
        chk("ra_in_settle_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_int", 32'(Integer), 32'd16);
        chk("ra_frac", 32'(Fraction), 32'd0);
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_ready", 32'(hop_ready), 32'd1);
        chk("ra_settled", 32'(settled), 32'd0);
        chk("ra_modclr", 32'(mod_clr), 32'd0);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (hop_done) n_done++;
        end
        chk("ra_no_done", 32'(n_done), 32'd0);
        #3 rst_n = 1'b1;
        do_hop("ra_after", 2'd2, 16'd0, 8'd0, 24'd0);

        // settle_cycles changed mid-SETTLE: this hop keeps S=5, the next uses 1
        write_entry(2'd2, 8'h55, 24'h0F0F0F);
        hop_valid = 1'b1; hop_idx = 2'd2; settle_cycles = 16'd5;
        tick();
        hop_valid = 1'b0;
        tick();
        chk("sc_int", 32'(Integer), 32'h55);
        tick();
        settle_cycles = 16'd1;
        for (int k = 4; k <= 9; k++) begin
            tick();
            chk($sformatf("sc_done_N%0d", k), 32'(hop_done), 32'(k == 9));
        end
        tick();
        do_hop("sc_next", 2'd2, 16'd1, 8'h55, 24'h0F0F0F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fracn_hop_ctrl.md
FRACN_HOP_CTRL -- requirements
Module: fracn_hop_ctrl

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 8: width of the integer divide word.
REQ-002 SHALL have parameter FRAC_WIDTH, default 24: width of the fractional word.
REQ-003 SHALL have parameter SETTLE_WIDTH, default 16: width of the settle counter.
REQ-004 SHALL have parameter INT_RESET, default 16: value of Integer after reset.
REQ-005 SHALL have port clk, input, 1: single clock; every register is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_we, input, 1: profile table write strobe.
REQ-008 SHALL have port cfg_addr, input, 2: profile index written.
REQ-009 SHALL have port cfg_int, input, INT_WIDTH: integer word written.
REQ-010 SHALL have port cfg_frac, input, FRAC_WIDTH: fraction word written.
REQ-011 SHALL have port settle_cycles, input, SETTLE_WIDTH: settle wait length S.
REQ-012 SHALL have port hop_valid, input, 1: hop request.
REQ-013 SHALL have port hop_idx, input, 2: target profile index.
REQ-014 SHALL have port hop_ready, output, 1: high exactly when state is IDLE.
REQ-015 SHALL have port Integer, output, INT_WIDTH: registered integer word to the divider.
REQ-016 SHALL have port Fraction, output, FRAC_WIDTH: registered fraction word to the divider.
REQ-017 SHALL have port mod_clr, output, 1: one-cycle clear pulse to the delta-sigma modulator.
REQ-018 SHALL have port busy, output, 1: high when state is not IDLE.
REQ-019 SHALL have port settled, output, 1: high once the last hop has completed settling.
REQ-020 SHALL have port hop_done, output, 1: one-cycle completion pulse.

Function
REQ-021 SHALL hold a 4-entry table of {int, frac}; cfg_we=1 writes entry cfg_addr on the clock edge, in any state.
REQ-022 SHALL implement FSM IDLE -> APPLY -> CLEAR -> SETTLE -> IDLE, one state per cycle except SETTLE.
REQ-023 SHALL accept a hop only on a cycle where hop_valid=1 and hop_ready=1, and capture hop_idx on that cycle.
REQ-024 SHALL ignore hop_valid while busy; the request is neither queued nor dropped silently (hop_ready=0 back-pressures it).
REQ-025 In APPLY, SHALL load Integer/Fraction from the captured entry; the table is read before any same-cycle write, so a write to that entry in APPLY affects only later hops.
REQ-026 In CLEAR, SHALL assert mod_clr=1 for that single cycle and load the settle counter with settle_cycles.
REQ-027 In SETTLE, SHALL go to IDLE when the counter is 0 and otherwise decrement it; SETTLE lasts S+1 cycles, including when S=0.
REQ-028 SHALL pulse hop_done=1 for one cycle, coincident with the first IDLE cycle after SETTLE; settled goes 1 on that same cycle.
REQ-029 SHALL clear settled to 0 on the cycle a hop is accepted.
REQ-030 Latency: for a hop accepted in cycle N, Integer/Fraction SHALL change at N+2 and mod_clr SHALL be high at N+2; hop_done SHALL be high at N+4+S.
REQ-031 SHALL sample settle_cycles only in CLEAR; changes to settle_cycles at other times have no effect on the hop in progress.
REQ-032 When hop_valid is held high with a new hop_idx, a back-to-back hop SHALL be accepted on the hop_done cycle (IDLE, hop_ready=1).
REQ-033 mod_clr, hop_done and busy SHALL be registered outputs, free of glitches.

Reset
REQ-034 With rst_n=0, SHALL asynchronously force: state IDLE, Integer=INT_RESET, Fraction=0, all table entries 0, counter 0, mod_clr=0, hop_done=0, settled=0, busy=0, hop_ready=1.
REQ-035 Reset asserted mid-hop SHALL abort the hop with no hop_done pulse; after release the block is idle and accepts a new hop on the first clock.

Verification
REQ-036 Write entry 1={20, 0x400000}, S=3, hop idx1 at cycle N -> Integer=20 and Fraction=0x400000 at N+2, mod_clr high only at N+2, hop_done high only at N+7.
REQ-037 S=0, hop idx0 (entry 0 = 0) -> SETTLE lasts 1 cycle, hop_done at N+4, Integer=0.
REQ-038 hop_valid held high during a hop with idx2 -> hop_ready=0 throughout busy; the idx2 hop is accepted on the hop_done cycle; exactly two mod_clr pulses occur.
REQ-039 cfg_we to entry 1 during APPLY of an idx1 hop -> the old entry-1 value is applied; the next idx1 hop applies the new value.
REQ-040 rst_n pulled low during SETTLE -> outputs are immediately at reset values; no hop_done pulse occurs; after release, a hop is accepted on the first clock with hop_valid=1.
REQ-041 settle_cycles changed from 5 to 1 during SETTLE -> the hop still takes S=5; the next hop uses 1.
